// File: rtl/vlt_lq_accum.sv
// ---------------------------------------------------------------------------
// vlt_lq_accum
//
// Load-queue vulnerability accumulator. Each load-queue deallocation event
// brings two shift amounts (each with an enable) and the residency duration
// of the entry. The weighted residency
//     (duration << shift1) + (duration << shift2)
// is formed in a registered stage (S1). It is then added into a saturating
// interval accumulator (S2), and an event counter is advanced alongside it.
// A valid/ack dump handshake takes an atomic snapshot of the running totals
// and clears them. Accumulation keeps running while a snapshot is pending.
//
// Parameters:
//   ACC_W  accumulator / dump width (>= 26)
//   CNT_W  event counter width
//
// Ports:
//   clk_i        clock, all state on the rising edge
//   rst_ni       asynchronous active-low reset
//   ev_v_i       deallocation event valid (at most one per cycle)
//   shift1_i     first shift amount;  shift1_v_i enables the term
//   shift2_i     second shift amount; shift2_v_i enables the term
//   duration_i   residency in cycles (modulo 1024)
//   dump_req_i   level-sampled snapshot request
//   dump_ack_i   consumer accepts the pending snapshot
//   dump_v_o     snapshot valid, held until acked
//   dump_acc_o   snapshot weighted-residency total
//   dump_cnt_o   snapshot event count
//   dump_sat_o   snapshot interval saturated (acc or cnt)
//   busy_o       snapshot pending (same as dump_v_o)
// ---------------------------------------------------------------------------
module vlt_lq_accum #(
    parameter int ACC_W = 48,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ev_v_i,
    input  logic [3:0]       shift1_i,
    input  logic             shift1_v_i,
    input  logic [3:0]       shift2_i,
    input  logic             shift2_v_i,
    input  logic [9:0]       duration_i,
    input  logic             dump_req_i,
    input  logic             dump_ack_i,
    output logic             dump_v_o,
    output logic [ACC_W-1:0] dump_acc_o,
    output logic [CNT_W-1:0] dump_cnt_o,
    output logic             dump_sat_o,
    output logic             busy_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    localparam logic [ACC_W-1:0] ACC_ONES = {ACC_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONES = {CNT_W{1'b1}};

    // S1 pipeline register
    logic             s1_v_q,  s1_v_d;
    logic [25:0]      s1_w_q,  s1_w_d;
    logic [25:0]      term1_s, term2_s;

    // S2 interval state
    logic [ACC_W-1:0] acc_q,   acc_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             sat_q,   sat_d;

    // Dump FSM and snapshot registers
    logic [0:0]       st_q,    st_d;
    logic [ACC_W-1:0] dump_acc_q, dump_acc_d;
    logic [CNT_W-1:0] dump_cnt_q, dump_cnt_d;
    logic             dump_sat_q, dump_sat_d;

    // Saturating next-interval values, shared by accumulate and snapshot paths
    logic [ACC_W-1:0] acc_add_s;
    logic [ACC_W:0]   acc_sum_s;
    logic             acc_ovf_s;
    logic [ACC_W-1:0] acc_next_s;
    logic             cnt_ovf_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic             sat_next_s;
    logic             take_s;

    // S1 weight: each term is at most 10+15 = 25 bits, the sum fits in 26.
    always_comb begin
        term1_s = 26'd0;
        term2_s = 26'd0;
        if (shift1_v_i) begin
            term1_s = {16'd0, duration_i} << shift1_i;
        end else begin
            term1_s = 26'd0;
        end
        if (shift2_v_i) begin
            term2_s = {16'd0, duration_i} << shift2_i;
        end else begin
            term2_s = 26'd0;
        end
        s1_v_d = ev_v_i;
        s1_w_d = term1_s + term2_s;
    end

    // S2 saturating add of the completing S1 event; counts zero-weight events too.
    always_comb begin
        if (s1_v_q) begin
            acc_add_s = ACC_W'(s1_w_q);
        end else begin
            acc_add_s = {ACC_W{1'b0}};
        end
        acc_sum_s  = {1'b0, acc_q} + {1'b0, acc_add_s};
        acc_ovf_s  = acc_sum_s[ACC_W];
        acc_next_s = acc_ovf_s ? ACC_ONES : acc_sum_s[ACC_W-1:0];
        cnt_ovf_s  = s1_v_q && (cnt_q == CNT_ONES);
        if (s1_v_q && !cnt_ovf_s) begin
            cnt_next_s = cnt_q + CNT_W'(1'b1);
        end else begin
            cnt_next_s = cnt_q;
        end
        sat_next_s = sat_q | acc_ovf_s | cnt_ovf_s;
    end

    // Dump FSM: a taken request snapshots the totals including the S2 event
    // completing on the same edge, and restarts the interval from zero.
    always_comb begin
        take_s     = 1'b0;
        st_d       = st_q;
        acc_d      = acc_next_s;
        cnt_d      = cnt_next_s;
        sat_d      = sat_next_s;
        dump_acc_d = dump_acc_q;
        dump_cnt_d = dump_cnt_q;
        dump_sat_d = dump_sat_q;
        case (st_q)
            ST_IDLE: begin
                if (dump_req_i) begin
                    take_s     = 1'b1;
                    st_d       = ST_PEND;
                    dump_acc_d = acc_next_s;
                    dump_cnt_d = cnt_next_s;
                    dump_sat_d = sat_next_s;
                    acc_d      = {ACC_W{1'b0}};
                    cnt_d      = {CNT_W{1'b0}};
                    sat_d      = 1'b0;
                end else begin
                    st_d = ST_IDLE;
                end
            end
            ST_PEND: begin
                // A request on the ack edge is not taken; it is seen from IDLE.
                if (dump_ack_i) begin
                    st_d = ST_IDLE;
                end else begin
                    st_d = ST_PEND;
                end
            end
            default: begin
                st_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset discards any in-flight snapshot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_v_q     <= 1'b0;
            s1_w_q     <= 26'd0;
            acc_q      <= {ACC_W{1'b0}};
            cnt_q      <= {CNT_W{1'b0}};
            sat_q      <= 1'b0;
            st_q       <= ST_IDLE;
            dump_acc_q <= {ACC_W{1'b0}};
            dump_cnt_q <= {CNT_W{1'b0}};
            dump_sat_q <= 1'b0;
        end else begin
            s1_v_q     <= s1_v_d;
            s1_w_q     <= s1_w_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            sat_q      <= sat_d;
            st_q       <= st_d;
            dump_acc_q <= dump_acc_d;
            dump_cnt_q <= dump_cnt_d;
            dump_sat_q <= dump_sat_d;
        end
    end

    assign dump_v_o   = (st_q == ST_PEND);
    assign busy_o     = (st_q == ST_PEND);
    assign dump_acc_o = dump_acc_q;
    assign dump_cnt_o = dump_cnt_q;
    assign dump_sat_o = dump_sat_q;

endmodule

// File: tb/tb_vlt_lq_accum.sv
// ---------------------------------------------------------------------------
// tb_vlt_lq_accum
//
// Directed bench for vlt_lq_accum (built with ACC_W=26 so saturation is
// reachable). A behavioural model in plain integer arithmetic tracks what
// the dump outputs must be. Every cycle the outputs are compared against the
// model on the falling edge. Hand-computed literals pin both the DUT and
// the model at the key points.
// ---------------------------------------------------------------------------
module tb_vlt_lq_accum;

    localparam int     ACC_W   = 26;
    localparam int     CNT_W   = 32;
    localparam longint ACC_MAX = (longint'(1) << ACC_W) - 1;
    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             ev_v_i;
    logic [3:0]       shift1_i;
    logic             shift1_v_i;
    logic [3:0]       shift2_i;
    logic             shift2_v_i;
    logic [9:0]       duration_i;
    logic             dump_req_i;
    logic             dump_ack_i;
    logic             dump_v_o;
    logic [ACC_W-1:0] dump_acc_o;
    logic [CNT_W-1:0] dump_cnt_o;
    logic             dump_sat_o;
    logic             busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    bit     m_s1_v;
    longint m_s1_w;
    longint m_acc, m_cnt, m_dacc, m_dcnt;
    bit     m_sat, m_pend, m_dsat;

    vlt_lq_accum #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .ev_v_i     (ev_v_i),
        .shift1_i   (shift1_i),
        .shift1_v_i (shift1_v_i),
        .shift2_i   (shift2_i),
        .shift2_v_i (shift2_v_i),
        .duration_i (duration_i),
        .dump_req_i (dump_req_i),
        .dump_ack_i (dump_ack_i),
        .dump_v_o   (dump_v_o),
        .dump_acc_o (dump_acc_o),
        .dump_cnt_o (dump_cnt_o),
        .dump_sat_o (dump_sat_o),
        .busy_o     (busy_o)
    );

    initial forever #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Weight as arithmetic: duration * 2^shift for each enabled term.
    function automatic longint weight(input int d, input int s1, input bit v1,
                                      input int s2, input bit v2);
        longint w;
        w = 0;
        if (v1) w += longint'(d) * (longint'(1) << s1);
        if (v2) w += longint'(d) * (longint'(1) << s2);
        return w;
    endfunction

    task automatic model_reset();
        m_s1_v = 1'b0; m_s1_w = 0;
        m_acc = 0; m_cnt = 0; m_sat = 1'b0;
        m_pend = 1'b0; m_dacc = 0; m_dcnt = 0; m_dsat = 1'b0;
    endtask

    // Interval totals after the event leaving the pipeline on this edge.
    task automatic model_edge();
        longint a, c;
        bit     s;
        if (!rst_ni) begin
            model_reset();
        end else begin
            a = m_acc + (m_s1_v ? m_s1_w : 0);
            c = m_cnt + (m_s1_v ? 1 : 0);
            s = m_sat;
            if (a > ACC_MAX) begin a = ACC_MAX; s = 1'b1; end
            if (c > CNT_MAX) begin c = CNT_MAX; s = 1'b1; end
            if (!m_pend && dump_req_i) begin
                m_dacc = a; m_dcnt = c; m_dsat = s;
                m_acc = 0; m_cnt = 0; m_sat = 1'b0;
                m_pend = 1'b1;
            end else begin
                m_acc = a; m_cnt = c; m_sat = s;
                if (m_pend && dump_ack_i) m_pend = 1'b0;
            end
            m_s1_v = ev_v_i;
            m_s1_w = ev_v_i ? weight(int'(duration_i), int'(shift1_i), shift1_v_i,
                                     int'(shift2_i), shift2_v_i) : 0;
        end
    endtask

    task automatic compare();
        check("dump_v",   longint'(dump_v_o),   longint'(m_pend));
        check("busy",     longint'(busy_o),     longint'(m_pend));
        check("dump_acc", longint'(dump_acc_o), m_dacc);
        check("dump_cnt", longint'(dump_cnt_o), m_dcnt);
        check("dump_sat", longint'(dump_sat_o), longint'(m_dsat));
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_edge();
        @(negedge clk_i);
        compare();
    endtask

    task automatic set_ev(input int d, input int s1, input bit v1, input int s2, input bit v2);
        ev_v_i     = 1'b1;
        duration_i = 10'(d);
        shift1_i   = 4'(s1);
        shift1_v_i = v1;
        shift2_i   = 4'(s2);
        shift2_v_i = v2;
    endtask

    task automatic no_ev();
        ev_v_i     = 1'b0;
        shift1_v_i = 1'b0;
        shift2_v_i = 1'b0;
    endtask

    task automatic do_dump();
        dump_req_i = 1'b1;
        tick();
        dump_req_i = 1'b0;
    endtask

    task automatic do_ack();
        dump_ack_i = 1'b1;
        tick();
        dump_ack_i = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0;
        no_ev();
        duration_i = 10'd0; shift1_i = 4'd0; shift2_i = 4'd0;
        dump_req_i = 1'b0; dump_ack_i = 1'b0;
        model_reset();

        // Reset state
        #1;
        check("rst_dump_v", longint'(dump_v_o), 0);
        check("rst_acc",    longint'(dump_acc_o), 0);
        check("rst_cnt",    longint'(dump_cnt_o), 0);
        tick(); tick();
        rst_ni = 1'b1;

        // Model pins
        check("model_w480",   weight(5, 6, 1'b1, 5, 1'b1), 480);
        check("model_w20460", weight(1023, 4, 1'b1, 2, 1'b1), 20460);
        check("model_w_sat",  weight(1023, 15, 1'b1, 15, 1'b1), 67043328);

        // Single event
        set_ev(5, 6, 1'b1, 5, 1'b1); tick();
        no_ev(); tick();
        do_dump();
        check("single_v",   longint'(dump_v_o), 1);
        check("single_acc", longint'(dump_acc_o), 480);
        check("single_cnt", longint'(dump_cnt_o), 1);
        check("single_sat", longint'(dump_sat_o), 0);
        do_ack();
        check("ack_v_low",    longint'(dump_v_o), 0);
        check("ack_retained", longint'(dump_acc_o), 480);

        // Zero weight and two-term event
        set_ev(100, 7, 1'b0, 9, 1'b0); tick();
        set_ev(1023, 4, 1'b1, 2, 1'b1); tick();
        no_ev(); tick();
        do_dump();
        check("zw_acc", longint'(dump_acc_o), 20460);
        check("zw_cnt", longint'(dump_cnt_o), 2);
        do_ack();

        // Back-to-back events with a mid-stream dump
        for (int i = 0; i < 10; i++) begin
            set_ev(1, 6, 1'b1, 5, 1'b1);
            dump_req_i = (i == 5);
            dump_ack_i = (i == 6);
            tick();
            if (i == 5) begin
                check("b2b_snap_acc", longint'(dump_acc_o), 480);
                check("b2b_snap_cnt", longint'(dump_cnt_o), 5);
            end
        end
        no_ev(); dump_req_i = 1'b0; dump_ack_i = 1'b0;
        tick(); tick();
        do_dump();
        check("b2b_next_acc", longint'(dump_acc_o), 480);
        check("b2b_next_cnt", longint'(dump_cnt_o), 5);
        do_ack();

        // Saturation
        set_ev(1023, 15, 1'b1, 15, 1'b1); tick(); tick();
        no_ev(); tick(); tick();
        do_dump();
        check("sat_acc", longint'(dump_acc_o), 67108863);
        check("sat_cnt", longint'(dump_cnt_o), 2);
        check("sat_flag", longint'(dump_sat_o), 1);
        do_ack();
        set_ev(1, 6, 1'b1, 5, 1'b1); tick();
        no_ev(); tick(); tick();
        do_dump();
        check("post_sat_acc",  longint'(dump_acc_o), 96);
        check("post_sat_flag", longint'(dump_sat_o), 0);
        do_ack();

        // Handshake: long pend, ignored request, ack+req same edge
        set_ev(3, 2, 1'b1, 0, 1'b0); tick();
        no_ev(); tick();
        do_dump();
        check("hs_acc", longint'(dump_acc_o), 12);
        for (int i = 0; i < 20; i++) begin
            if (i == 4) begin
                set_ev(1, 0, 1'b1, 0, 1'b0);
                dump_req_i = 1'b1;
            end else begin
                no_ev();
                dump_req_i = 1'b0;
            end
            tick();
        end
        check("hs_hold_v",   longint'(dump_v_o), 1);
        check("hs_hold_acc", longint'(dump_acc_o), 12);
        dump_ack_i = 1'b1; dump_req_i = 1'b1; tick();
        dump_ack_i = 1'b0;
        check("hs_ackreq_v", longint'(dump_v_o), 0);
        do_dump();
        check("hs_new_v",   longint'(dump_v_o), 1);
        check("hs_new_acc", longint'(dump_acc_o), 1);
        check("hs_new_cnt", longint'(dump_cnt_o), 1);
        do_ack();

        // Asynchronous reset mid-PEND
        set_ev(2, 3, 1'b1, 0, 1'b0); tick();
        no_ev(); tick();
        do_dump();
        check("pre_rst_acc", longint'(dump_acc_o), 16);
        set_ev(7, 0, 1'b1, 0, 1'b0); tick();
        no_ev();
        #2;
        rst_ni = 1'b0;
        model_reset();
        #1;
        check("arst_v",    longint'(dump_v_o), 0);
        check("arst_busy", longint'(busy_o), 0);
        check("arst_acc",  longint'(dump_acc_o), 0);
        check("arst_cnt",  longint'(dump_cnt_o), 0);
        check("arst_sat",  longint'(dump_sat_o), 0);
        tick();
        rst_ni = 1'b1;
        set_ev(1, 6, 1'b1, 5, 1'b1); tick();
        no_ev(); tick(); tick();
        do_dump();
        check("post_rst_acc", longint'(dump_acc_o), 96);
        check("post_rst_cnt", longint'(dump_cnt_o), 1);
        do_ack();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
